inmem_rd_arbiter: RTL and testbench
===================================

Name: inmem_rd_arbiter

Overview:
- Shares the single input-memory read port (port B) between requesters: packet builder, data-integrity checker and CRC checker.
- Issues at most one read per cycle and grants requesters in round-robin order.
- Supports locked bursts so the CRC walk can read consecutive beats without interleaving. Burst length is capped so no requester starves.
- Returns read data tagged to the requester that issued the read, after a fixed memory latency.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = packet builder, 1 = DI checker, 2 = CRC checker).
- ADDR_W, 14, memory word-address width.
- DATA_W, 32, memory data width.
- RD_LAT, 1, memory read latency in cycles (1..4).
- MAX_BURST, 8, maximum consecutive grants to one locked owner.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester read request.
- lock_i  in  NUM_REQ  per-requester burst-hold request; meaningful only with req_i.
- addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester i uses [i*ADDR_W +: ADDR_W].
- gnt_o  out  NUM_REQ  one-hot; address of the granted requester is issued this cycle.
- rvalid_o  out  NUM_REQ  one-hot; rdata_o belongs to this requester.
- rdata_o  out  DATA_W  read data, broadcast to all requesters.
- mem_en_o  out  1  memory read enable.
- mem_addr_o  out  ADDR_W  memory read address.
- mem_data_i  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en_o.
- owner_o  out  $clog2(NUM_REQ)  current or last grant index.
- busy_o  out  1  high while in the LOCKED state.
- proto_err_o  out  1  sticky flag: lock_i[i] seen high while req_i[i] low.

Behaviour:
- Reset values (asynchronous): all outputs 0; FSM in ARB_IDLE; rr_ptr=0; burst_cnt=0; response pipeline cleared. In-flight reads at reset are dropped and never produce rvalid_o.
- Grant path is combinational in the issue cycle:
  - mem_en_o = |gnt_o.
  - mem_addr_o = addr of the granted requester; 0 when no grant.
- Round-robin search starts at index (last_owner+1) mod NUM_REQ and wraps. When no request is pending there is no grant and rr_ptr holds.
- FSM states:
  - ARB_IDLE: grant the round-robin winner w.
    - If lock_i[w]=1: go to ARB_LOCKED, owner=w, burst_cnt=1.
    - Otherwise stay in ARB_IDLE; last_owner=w.
  - ARB_LOCKED, owner still requesting with lock (req_i[owner]&&lock_i[owner]) and burst_cnt<MAX_BURST: grant the owner only; burst_cnt++.
  - ARB_LOCKED, owner drops req or lock: release. Round-robin runs in the same cycle starting after the owner; the owner is excluded from that cycle's search.
  - ARB_LOCKED, burst_cnt==MAX_BURST: forced release. Same as above; the owner must re-win round-robin. A winner with lock high re-enters ARB_LOCKED with burst_cnt=1.
- Response pipeline: RD_LAT-deep shift register of {valid, id}, loaded from gnt_o each cycle.
  - rvalid_o[id] is asserted exactly RD_LAT cycles after gnt_o[id].
  - rdata_o=mem_data_i when valid; otherwise rdata_o holds its last value.
  - Back-to-back grants give back-to-back responses in issue order.
- Requester-side handshake:
  - Requester holds req_i and addr_i stable until it sees gnt_o.
  - Address change without grant is legal (newest value is used).
  - Requester may drop req_i at any time; no grant means no read.
- proto_err_o is set by lock_i[i] && !req_i[i] and cleared only by reset. Such a lock is otherwise ignored.
- Widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits and never wraps.
  - rr_ptr wraps modulo NUM_REQ; non-power-of-2 NUM_REQ must wrap at NUM_REQ-1 → 0.
- Single requester repeatedly requesting without lock: granted every cycle (full throughput).

Decomposition:
- Shared package pkt_chk_pkg holds:
  - the arb_state_t enum (ARB_IDLE, ARB_LOCKED);
  - requester index constants REQ_PB=0, REQ_DI=1, REQ_CRC=2.
- One natural sub-module: rr_pick. It is combinational and takes (req vector, start pointer, exclude mask) and returns (valid, index). It is reused later for the out-memory port.

Test Plan:
- Reset, then req_i=3'b111 with no locks for 6 cycles → grants 1,2,0,1,2,0 (rr_ptr starts 0, so the search starts at 1); rvalid_o follows each grant by RD_LAT=1 with matching data.
- req_i[2]=1, lock_i[2]=1 held; req_i[0] high throughout; MAX_BURST=8 → 8 consecutive CRC grants, busy_o=1, then the PB grant; then the CRC requester re-locks.
- Locked owner 2 drops lock after 3 grants while req_i[1] pending → cycle 4 grants 1, busy_o falls the same cycle.
- RD_LAT=3, alternating grants 0/1 with addresses 0x10/0x20 → rvalid_o order 0,1,0,1, each 3 cycles after its grant, rdata matching memory contents.
- Assert reset while in ARB_LOCKED with 1 read in flight → all outputs 0 immediately; no rvalid_o after reset release; first grant goes to index 1.
- lock_i[1]=1 with req_i[1]=0 → proto_err_o=1 and stays 1; no grant issued to 1; other requesters unaffected.

Source files
------------

// File: rtl/pkt_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_chk_pkg
//  Description : Shared types and constants for the packet-checker memory
//                arbiters (arbiter FSM states, requester index assignments).
//  Revision    : 1.0 - initial release
// ============================================================================
package pkt_chk_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Requester slots on the input-memory read port
    localparam int unsigned REQ_PB  = 0;  // packet builder
    localparam int unsigned REQ_DI  = 1;  // data-integrity checker
    localparam int unsigned REQ_CRC = 2;  // CRC checker

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans the request vector
//                starting at start_i, wrapping at N-1 -> 0, skipping any
//                index set in excl_i, and returns the first hit.
//  Ports       : req_i   - request vector
//                start_i - index where the search begins (must be < N)
//                excl_i  - mask of indices removed from this search
//                valid_o - a winner was found
//                idx_o   - index of the winner (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic [N-1:0]  excl_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0] avail;
    assign avail = req_i & ~excl_i;

    always_comb begin
        logic [IW:0] pos;
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo by subtraction so non-power-of-2 N wraps correctly
            pos = {1'b0, start_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!valid_o && avail[pos[IW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = pos[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inmem_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inmem_rd_arbiter
//  Description : Round-robin arbiter sharing the input-memory read port B
//                between the packet builder, DI checker and CRC checker.
//                Supports capped locked bursts and returns read data tagged
//                to the issuing requester after RD_LAT cycles.
//  Ports       : clk, reset    - clock, asynchronous active-high reset
//                req_i/lock_i  - per-requester read request / burst hold
//                addr_i        - packed per-requester word addresses
//                gnt_o         - one-hot grant, address issued this cycle
//                rvalid_o      - one-hot owner of rdata_o
//                rdata_o       - read data broadcast to all requesters
//                mem_en_o/mem_addr_o/mem_data_i - memory read port
//                owner_o       - current or last granted index
//                busy_o        - arbiter is inside a locked burst
//                proto_err_o   - sticky: lock seen without request
//  Revision    : 1.0 - initial release
// ============================================================================
module inmem_rd_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        mem_en_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    input  logic [DATA_W-1:0]           mem_data_i,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic                        busy_o,
    output logic                        proto_err_o
);
    import pkt_chk_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;     // last granted index
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic                 proto_err_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [RD_LAT-1:0]    pv_q;                   // response pipe valid
    logic [IW-1:0]        pid_q [RD_LAT];         // response pipe id

    logic                 hold;
    logic [IW-1:0]        pick_start;
    logic [NUM_REQ-1:0]   pick_excl;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic                 gnt_vld;
    logic [IW-1:0]        gnt_idx;

    // Owner keeps the port while it asks with lock and is under the cap
    assign hold = (state_q == ARB_LOCKED) && req_i[rr_ptr_q] && lock_i[rr_ptr_q]
                  && (burst_cnt_q < BW'(MAX_BURST));

    assign pick_start = (rr_ptr_q == IW'(NUM_REQ - 1)) ? '0 : rr_ptr_q + IW'(1);
    // On release the outgoing owner must not win the same cycle
    assign pick_excl  = (state_q == ARB_LOCKED) ? (NUM_REQ'(1) << rr_ptr_q) : '0;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_i   (req_i),
        .start_i (pick_start),
        .excl_i  (pick_excl),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // ------------------------------------------------------------------
    // Next-state / grant logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_vld     = 1'b0;
        gnt_idx     = rr_ptr_q;
        if (reset) begin
            // No grant may escape while reset is asserted
            gnt_vld = 1'b0;
        end else if (hold) begin
            gnt_vld     = 1'b1;
            burst_cnt_d = burst_cnt_q + BW'(1);
        end else if (pick_valid) begin
            gnt_vld  = 1'b1;
            gnt_idx  = pick_idx;
            rr_ptr_d = pick_idx;
            // A winner only reaches here with req high, so its lock is valid
            if (lock_i[pick_idx]) begin
                state_d     = ARB_LOCKED;
                burst_cnt_d = BW'(1);
            end else begin
                state_d     = ARB_IDLE;
                burst_cnt_d = '0;
            end
        end else begin
            state_d     = ARB_IDLE;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            proto_err_q <= proto_err_q | (|(lock_i & ~req_i));
        end
    end

    assign gnt_o    = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign mem_en_o = |gnt_o;

    always_comb begin
        mem_addr_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) begin
                mem_addr_o = addr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Busy reflects the state following this cycle's grant, so it rises with
    // the first locked grant and falls in the release cycle itself.
    assign busy_o      = (state_d == ARB_LOCKED);
    assign owner_o     = rr_ptr_q;
    assign proto_err_o = proto_err_q;

    // ------------------------------------------------------------------
    // Response pipeline: tags each read with its requester id
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pid_q[i] <= '0;
            end
        end else begin
            pv_q[0]  <= gnt_vld;
            pid_q[0] <= gnt_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pid_q[i] <= pid_q[i-1];
            end
        end
    end

    assign rvalid_o = pv_q[RD_LAT-1] ? (NUM_REQ'(1) << pid_q[RD_LAT-1]) : '0;
    // Memory data passes straight through on a response, else last value held
    assign rdata_o  = pv_q[RD_LAT-1] ? mem_data_i : rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_o;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inmem_rd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_inmem_rd_arbiter
//  Description : Self-checking bench for inmem_rd_arbiter. Two instances:
//                RD_LAT=1 (main) and RD_LAT=3 (latency ordering). Expected
//                responses are queued when grants are expected and checked
//                when they fall due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inmem_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 14;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {2'b00, a, 2'b00, a};
    endfunction

    // ---------------- instance 1 : RD_LAT = 1 ----------------
    logic [N-1:0]    req1 = '0, lock1 = '0;
    logic [N*AW-1:0] addr1 = '0;
    logic [N-1:0]    gnt1, rvalid1;
    logic [DW-1:0]   rdata1, mdata1;
    logic            men1, busy1, perr1;
    logic [AW-1:0]   maddr1;
    logic [1:0]      owner1;

    inmem_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset), .req_i(req1), .lock_i(lock1), .addr_i(addr1),
        .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1), .mem_en_o(men1),
        .mem_addr_o(maddr1), .mem_data_i(mdata1), .owner_o(owner1), .busy_o(busy1),
        .proto_err_o(perr1)
    );

    logic [DW-1:0] m1_q = '0;
    always @(posedge clk) m1_q <= men1 ? memf(maddr1) : 32'hDEAD_BEEF;
    assign mdata1 = m1_q;

    // ---------------- instance 3 : RD_LAT = 3 ----------------
    logic [N-1:0]    req3 = '0, lock3 = '0;
    logic [N*AW-1:0] addr3 = '0;
    logic [N-1:0]    gnt3, rvalid3;
    logic [DW-1:0]   rdata3, mdata3;
    logic            men3, busy3, perr3;
    logic [AW-1:0]   maddr3;
    logic [1:0]      owner3;

    inmem_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_BURST(8)) dut3 (
        .clk(clk), .reset(reset), .req_i(req3), .lock_i(lock3), .addr_i(addr3),
        .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3), .mem_en_o(men3),
        .mem_addr_o(maddr3), .mem_data_i(mdata3), .owner_o(owner3), .busy_o(busy3),
        .proto_err_o(perr3)
    );

    logic [DW-1:0] m3_q [3];
    always @(posedge clk) begin
        m3_q[0] <= men3 ? memf(maddr3) : 32'hDEAD_BEEF;
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end
    assign mdata3 = m3_q[2];

    // ---------------- scoreboards ----------------
    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        int            due;
    } exp_t;

    exp_t sb1[$];
    exp_t sb3[$];
    logic [DW-1:0] last_rd1 = '0, last_rd3 = '0;
    logic [N-1:0]  erv1, erv3;
    logic [DW-1:0] erd1, erd3;

    always @(negedge clk) begin
        if (!reset) begin
            n_chk++;
            if (sb1.size() > 0 && sb1[0].due <= cyc) begin
                erv1 = 3'b001 << sb1[0].id;
                erd1 = memf(sb1[0].addr);
                if (rvalid1 !== erv1 || rdata1 !== erd1) begin
                    n_fail++;
                    $display("FAIL rsp_lat1 cyc=%0d rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                             cyc, rvalid1, rdata1, erv1, erd1);
                end
                last_rd1 = erd1;
                void'(sb1.pop_front());
            end else if (rvalid1 !== 3'b000) begin
                n_fail++;
                $display("FAIL rsp_lat1_idle cyc=%0d rvalid=%b expected 000", cyc, rvalid1);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            n_chk++;
            if (sb3.size() > 0 && sb3[0].due <= cyc) begin
                erv3 = 3'b001 << sb3[0].id;
                erd3 = memf(sb3[0].addr);
                if (rvalid3 !== erv3 || rdata3 !== erd3) begin
                    n_fail++;
                    $display("FAIL rsp_lat3 cyc=%0d rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                             cyc, rvalid3, rdata3, erv3, erd3);
                end
                last_rd3 = erd3;
                void'(sb3.pop_front());
            end else if (rvalid3 !== 3'b000) begin
                n_fail++;
                $display("FAIL rsp_lat3_idle cyc=%0d rvalid=%b expected 000", cyc, rvalid3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({gnt1, rvalid1, men1, busy1, perr1, owner1} !== 11'b0 || rdata1 !== '0 || maddr1 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs gnt=%b rvalid=%b men=%b busy=%b perr=%b owner=%0d rdata=%h maddr=%h expected all 0",
                     gnt1, rvalid1, men1, busy1, perr1, owner1, rdata1, maddr1);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain1();
        int guard = 0;
        req1  = '0;
        lock1 = '0;
        @(negedge clk);
        n_chk++;
        if (gnt1 !== 3'b000 || men1 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_grant gnt=%b men=%b expected 000/0", gnt1, men1);
        end
        tick();
        while (sb1.size() > 0 && guard < 10) begin
            tick();
            guard++;
        end
        n_chk++;
        if (sb1.size() != 0) begin
            n_fail++;
            $display("FAIL drain_lat1 pending=%0d expected 0", sb1.size());
            sb1.delete();
        end
        @(negedge clk);
        n_chk++;
        if (rdata1 !== last_rd1) begin
            n_fail++;
            $display("FAIL rdata_hold rdata=%h expected %h", rdata1, last_rd1);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int   exp_id[6] = '{1, 2, 0, 1, 2, 0};
        exp_t e;
        logic [AW-1:0] ea;
        for (int i = 0; i < N; i++) addr1[i*AW +: AW] = 14'h100 + AW'(i);
        req1  = 3'b111;
        lock1 = 3'b000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ea = 14'h100 + AW'(exp_id[k]);
            n_chk++;
            if (gnt1 !== (3'b001 << exp_id[k]) || maddr1 !== ea || men1 !== 1'b1 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_grant k=%0d gnt=%b maddr=%h men=%b busy=%b expected gnt=%b maddr=%h men=1 busy=0",
                         k, gnt1, maddr1, men1, busy1, 3'b001 << exp_id[k], ea);
            end
            e.id = exp_id[k]; e.addr = ea; e.due = cyc + 1;
            sb1.push_back(e);
            tick();
        end
        drain1();
    endtask

    task automatic test_burst_cap();
        int   exp_id[10]   = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2};
        bit   exp_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        exp_t e;
        logic [AW-1:0] ea;
        req1  = 3'b101;
        lock1 = 3'b100;
        for (int k = 0; k < 10; k++) begin
            addr1[2*AW +: AW] = 14'h200 + AW'(k);
            @(negedge clk);
            ea = (exp_id[k] == 2) ? 14'h200 + AW'(k) : 14'h100;
            n_chk++;
            if (gnt1 !== (3'b001 << exp_id[k]) || maddr1 !== ea || busy1 !== exp_busy[k]) begin
                n_fail++;
                $display("FAIL burst_grant k=%0d gnt=%b maddr=%h busy=%b expected gnt=%b maddr=%h busy=%b",
                         k, gnt1, maddr1, busy1, 3'b001 << exp_id[k], ea, exp_busy[k]);
            end
            e.id = exp_id[k]; e.addr = ea; e.due = cyc + 1;
            sb1.push_back(e);
            tick();
        end
        req1  = 3'b000;
        lock1 = 3'b000;
        @(negedge clk);
        n_chk++;
        if (gnt1 !== 3'b000 || busy1 !== 1'b0 || owner1 !== 2'd2) begin
            n_fail++;
            $display("FAIL burst_release_idle gnt=%b busy=%b owner=%0d expected 000/0/2", gnt1, busy1, owner1);
        end
        tick();
        drain1();
    endtask

    task automatic test_lock_drop();
        int   exp_id[5]   = '{1, 2, 2, 2, 1};
        bit   exp_busy[5] = '{0, 1, 1, 1, 0};
        logic [N-1:0] rq[5] = '{3'b010, 3'b110, 3'b110, 3'b110, 3'b110};
        logic [N-1:0] lk[5] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b000};
        exp_t e;
        logic [AW-1:0] ea;
        for (int i = 0; i < N; i++) addr1[i*AW +: AW] = 14'h300 + AW'(i);
        for (int k = 0; k < 5; k++) begin
            req1  = rq[k];
            lock1 = lk[k];
            @(negedge clk);
            ea = 14'h300 + AW'(exp_id[k]);
            n_chk++;
            if (gnt1 !== (3'b001 << exp_id[k]) || maddr1 !== ea || busy1 !== exp_busy[k]) begin
                n_fail++;
                $display("FAIL lockdrop_grant k=%0d gnt=%b maddr=%h busy=%b expected gnt=%b maddr=%h busy=%b",
                         k, gnt1, maddr1, busy1, 3'b001 << exp_id[k], ea, exp_busy[k]);
            end
            e.id = exp_id[k]; e.addr = ea; e.due = cyc + 1;
            sb1.push_back(e);
            tick();
        end
        drain1();
    endtask

    task automatic test_proto_err();
        logic [N-1:0] exp_g[3]  = '{3'b100, 3'b001, 3'b000};
        bit           exp_pe[3] = '{0, 1, 1};
        logic [N-1:0] rq[3]     = '{3'b101, 3'b101, 3'b000};
        logic [N-1:0] lk[3]     = '{3'b010, 3'b010, 3'b000};
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            req1  = rq[k];
            lock1 = lk[k];
            @(negedge clk);
            n_chk++;
            if (gnt1 !== exp_g[k] || perr1 !== exp_pe[k] || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL proto_err k=%0d gnt=%b perr=%b busy=%b expected gnt=%b perr=%b busy=0",
                         k, gnt1, perr1, busy1, exp_g[k], exp_pe[k]);
            end
            if (exp_g[k] != 3'b000) begin
                e.id   = (exp_g[k] == 3'b100) ? 2 : 0;
                e.addr = 14'h300 + AW'(e.id);
                e.due  = cyc + 1;
                sb1.push_back(e);
            end
            tick();
        end
        drain1();
        n_chk++;
        if (perr1 !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_err_sticky perr=%b expected 1", perr1);
        end
    endtask

    task automatic test_reset_in_burst();
        exp_t e;
        req1  = 3'b100;
        lock1 = 3'b100;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (gnt1 !== 3'b100 || busy1 !== 1'b1) begin
                n_fail++;
                $display("FAIL prereset_lock k=%0d gnt=%b busy=%b expected 100/1", k, gnt1, busy1);
            end
            e.id = 2; e.addr = 14'h302; e.due = cyc + 1;
            sb1.push_back(e);
            tick();
        end
        // Second locked read is now in flight
        reset = 1'b1;
        sb1.delete();
        last_rd1 = '0;
        #1;
        n_chk++;
        if ({gnt1, rvalid1, men1, busy1, perr1, owner1} !== 11'b0 || rdata1 !== '0 || maddr1 !== '0) begin
            n_fail++;
            $display("FAIL reset_in_burst gnt=%b rvalid=%b men=%b busy=%b perr=%b owner=%0d rdata=%h maddr=%h expected all 0",
                     gnt1, rvalid1, men1, busy1, perr1, owner1, rdata1, maddr1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req1  = 3'b111;
        lock1 = 3'b000;
        @(negedge clk);
        n_chk++;
        if (gnt1 !== 3'b010 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_grant gnt=%b busy=%b expected 010/0", gnt1, busy1);
        end
        e.id = 1; e.addr = 14'h301; e.due = cyc + 1;
        sb1.push_back(e);
        tick();
        drain1();
    endtask

    task automatic test_rd_lat3();
        int   exp_id[4] = '{0, 1, 0, 1};
        logic [N-1:0] rq[4] = '{3'b001, 3'b010, 3'b001, 3'b010};
        exp_t e;
        logic [AW-1:0] ea;
        int guard = 0;
        addr3[0*AW +: AW] = 14'h010;
        addr3[1*AW +: AW] = 14'h020;
        for (int k = 0; k < 4; k++) begin
            req3 = rq[k];
            @(negedge clk);
            ea = (exp_id[k] == 0) ? 14'h010 : 14'h020;
            n_chk++;
            if (gnt3 !== (3'b001 << exp_id[k]) || maddr3 !== ea) begin
                n_fail++;
                $display("FAIL lat3_grant k=%0d gnt=%b maddr=%h expected gnt=%b maddr=%h",
                         k, gnt3, maddr3, 3'b001 << exp_id[k], ea);
            end
            e.id = exp_id[k]; e.addr = ea; e.due = cyc + 3;
            sb3.push_back(e);
            tick();
        end
        req3 = 3'b000;
        while (sb3.size() > 0 && guard < 12) begin
            tick();
            guard++;
        end
        n_chk++;
        if (sb3.size() != 0) begin
            n_fail++;
            $display("FAIL drain_lat3 pending=%0d expected 0", sb3.size());
            sb3.delete();
        end
        @(negedge clk);
        n_chk++;
        if (rdata3 !== last_rd3) begin
            n_fail++;
            $display("FAIL lat3_rdata_hold rdata=%h expected %h", rdata3, last_rd3);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_lock_drop();
        n_chk++;
        if (perr1 !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_err_clean perr=%b expected 0", perr1);
        end
        test_proto_err();
        test_reset_in_burst();
        test_rd_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
